// File: rtl/stopwatch_lap_if.sv
// rtl/stopwatch_lap_if.sv - preset load and lap readback bus for stopwatch_lap
interface stopwatch_lap_if #(
  parameter int LAP_IW = 2
);
  logic              load;
  logic [7:0]        load_min;
  logic [7:0]        load_sec;
  logic [LAP_IW-1:0] lap_sel;
  logic [23:0]       lap_time;
  logic [LAP_IW:0]   lap_count;
  logic              lap_full;

  modport master (
    output load, load_min, load_sec, lap_sel,
    input  lap_time, lap_count, lap_full
  );

  modport slave (
    input  load, load_min, load_sec, lap_sel,
    output lap_time, lap_count, lap_full
  );
endinterface

// File: rtl/stopwatch_lap.sv
// rtl/stopwatch_lap.sv - BCD MM:SS.CC up/down stopwatch with lap capture buffer
module stopwatch_lap #(
  parameter int TICK_DIV  = 10,
  parameter int LAP_DEPTH = 4,
  parameter int LAP_IW    = 2,
  parameter int MIN_MAX   = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ref_tick,
  input  logic        btn_start_n,
  input  logic        btn_lap_n,
  input  logic        btn_clr_n,
  input  logic        mode_down,
  stopwatch_lap_if.slave bus,
  output logic [23:0] cur_time,
  output logic        running,
  output logic        expired
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0] MIN_BCD = 8'(((MIN_MAX / 10) << 4) + (MIN_MAX % 10));
  localparam logic [LAP_IW:0] LAP_FULL_CNT = (LAP_IW + 1)'(LAP_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t            state;
  logic              down_q;
  logic [23:0]       preset;
  logic [DW-1:0]     div;
  logic [LAP_IW:0]   lap_cnt;
  logic [23:0]       lap_mem [LAP_DEPTH];

  // Bit 2 of each shift register is the previous synchronised sample for edge detection.
  logic [2:0] ref_sh, start_sh, lap_sh, clr_sh;

  logic        tick, start_ev, lap_ev, clr_ev, cs_en, lap_ok, start_ok;
  logic [23:0] load_val, base, t_inc, t_dec;
  logic [3:0]  mo, mt, so, st;
  logic [7:0]  mm;

  function automatic logic [23:0] time_inc(input logic [23:0] t);
    logic [23:0] r;
    r = t;
    if (t[3:0] != 4'd9) r[3:0] = t[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd9) r[7:4] = t[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) r[11:8] = t[11:8] + 4'd1;
        else begin
          r[11:8] = 4'd0;
          if (t[15:12] != 4'd5) r[15:12] = t[15:12] + 4'd1;
          else begin
            r[15:12] = 4'd0;
            if (t[23:16] == MIN_BCD) r[23:16] = 8'h00;
            else if (t[19:16] != 4'd9) r[19:16] = t[19:16] + 4'd1;
            else begin
              r[19:16] = 4'd0;
              r[23:20] = t[23:20] + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [23:0] time_dec(input logic [23:0] t);
    logic [23:0] r;
    r = t;
    if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd9;
        if (t[11:8] != 4'd0) r[11:8] = t[11:8] - 4'd1;
        else begin
          r[11:8] = 4'd9;
          if (t[15:12] != 4'd0) r[15:12] = t[15:12] - 4'd1;
          else begin
            r[15:12] = 4'd5;
            if (t[19:16] != 4'd0) r[19:16] = t[19:16] - 4'd1;
            else begin
              r[19:16] = 4'd9;
              r[23:20] = t[23:20] - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  assign tick     = ref_sh[1] & ~ref_sh[2];
  assign start_ev = ~start_sh[1] & start_sh[2];
  assign lap_ev   = ~lap_sh[1] & lap_sh[2];
  assign clr_ev   = ~clr_sh[1] & clr_sh[2];
  assign cs_en    = (state == RUN) && tick && (div == DW'(TICK_DIV - 1));
  assign lap_ok   = lap_ev && (lap_cnt != LAP_FULL_CNT) && (state == RUN || state == PAUSE);
  assign t_inc    = time_inc(cur_time);
  assign t_dec    = time_dec(cur_time);

  always_comb begin
    mo = (bus.load_min[3:0] > 4'd9) ? 4'd9 : bus.load_min[3:0];
    mt = (bus.load_min[7:4] > 4'd9) ? 4'd9 : bus.load_min[7:4];
    so = (bus.load_sec[3:0] > 4'd9) ? 4'd9 : bus.load_sec[3:0];
    st = (bus.load_sec[7:4] > 4'd5) ? 4'd5 : bus.load_sec[7:4];
    mm = ({mt, mo} > MIN_BCD) ? MIN_BCD : {mt, mo};
    load_val = {mm, st, so, 8'h00};
    // A same-cycle load is what start sees, so zero-preset rejection uses it.
    base     = bus.load ? load_val : cur_time;
    start_ok = !(mode_down && base[23:8] == 16'h0000);
  end

  assign bus.lap_count = lap_cnt;
  assign bus.lap_full  = (lap_cnt == LAP_FULL_CNT);
  assign bus.lap_time  = ({1'b0, bus.lap_sel} < lap_cnt) ? lap_mem[bus.lap_sel] : 24'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_sh   <= 3'b000;
      start_sh <= 3'b111;
      lap_sh   <= 3'b111;
      clr_sh   <= 3'b111;
      state    <= IDLE;
      down_q   <= 1'b0;
      preset   <= 24'h0;
      div      <= '0;
      lap_cnt  <= '0;
      cur_time <= 24'h0;
      running  <= 1'b0;
      expired  <= 1'b0;
    end else begin
      ref_sh   <= {ref_sh[1:0], ref_tick};
      start_sh <= {start_sh[1:0], btn_start_n};
      lap_sh   <= {lap_sh[1:0], btn_lap_n};
      clr_sh   <= {clr_sh[1:0], btn_clr_n};

      if (clr_ev) begin
        state    <= IDLE;
        running  <= 1'b0;
        expired  <= 1'b0;
        div      <= '0;
        lap_cnt  <= '0;
        cur_time <= down_q ? preset : 24'h0;
      end else begin
        if (lap_ok) begin
          lap_mem[lap_cnt[LAP_IW-1:0]] <= cur_time;
          lap_cnt <= lap_cnt + 1'b1;
        end
        case (state)
          IDLE: begin
            div <= '0;
            if (bus.load) begin
              preset   <= load_val;
              cur_time <= load_val;
            end
            if (start_ev && start_ok) begin
              state   <= RUN;
              running <= 1'b1;
              down_q  <= mode_down;
            end
          end
          RUN: begin
            if (tick) div <= (div == DW'(TICK_DIV - 1)) ? '0 : div + 1'b1;
            if (cs_en && down_q && t_dec == 24'h0) begin
              cur_time <= 24'h0;
              state    <= EXPIRED;
              running  <= 1'b0;
              expired  <= 1'b1;
            end else begin
              if (cs_en) cur_time <= down_q ? t_dec : t_inc;
              if (start_ev) begin
                state   <= PAUSE;
                running <= 1'b0;
              end
            end
          end
          PAUSE: begin
            if (start_ev) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_lap.sv
// tb/tb_stopwatch_lap.sv - directed self-checking bench for stopwatch_lap
module tb_stopwatch_lap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ref_tick = 1'b0;
  logic        btn_start_n = 1'b1;
  logic        btn_lap_n = 1'b1;
  logic        btn_clr_n = 1'b1;
  logic        mode_down = 1'b0;
  logic [23:0] cur_time;
  logic        running;
  logic        expired;

  int n_checks = 0;
  int n_pass = 0;

  stopwatch_lap_if #(.LAP_IW(2)) bus ();

  stopwatch_lap #(
    .TICK_DIV(10), .LAP_DEPTH(4), .LAP_IW(2), .MIN_MAX(59)
  ) dut (
    .clk(clk), .rst(rst), .ref_tick(ref_tick),
    .btn_start_n(btn_start_n), .btn_lap_n(btn_lap_n), .btn_clr_n(btn_clr_n),
    .mode_down(mode_down), .bus(bus),
    .cur_time(cur_time), .running(running), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) ref_tick = 1'b1;
      repeat (4) @(negedge clk);
      ref_tick = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  // which: 0 start, 1 lap, 2 clr
  task automatic press(input int which);
    @(negedge clk);
    if (which == 0) btn_start_n = 1'b0;
    else if (which == 1) btn_lap_n = 1'b0;
    else btn_clr_n = 1'b0;
    repeat (6) @(negedge clk);
    btn_start_n = 1'b1;
    btn_lap_n   = 1'b1;
    btn_clr_n   = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] mn, input logic [7:0] sc);
    @(negedge clk);
    bus.load = 1'b1;
    bus.load_min = mn;
    bus.load_sec = sc;
    @(negedge clk);
    bus.load = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.load = 1'b0;
    bus.load_min = 8'h00;
    bus.load_sec = 8'h00;
    bus.lap_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cur", 32'(cur_time), 32'h0);
    check("rst_run", 32'(running), 32'h0);
    check("rst_exp", 32'(expired), 32'h0);
    check("rst_lapcnt", 32'(bus.lap_count), 32'h0);
    check("rst_full", 32'(bus.lap_full), 32'h0);
    check("rst_laptime", 32'(bus.lap_time), 32'h0);

    // Up count 1.23 s
    press(0);
    check("up_running", 32'(running), 32'h1);
    ticks(1230);
    check("up_123", 32'(cur_time), 32'h000123);
    check("up_still_run", 32'(running), 32'h1);
    press(2);
    check("clr_run", 32'(running), 32'h0);
    check("clr_cur", 32'(cur_time), 32'h0);

    // Saturating load, then minute wrap
    do_load(8'h7A, 8'h6C);
    check("load_sat", 32'(cur_time), 32'h595900);
    do_load(8'h59, 8'h59);
    check("load_5959", 32'(cur_time), 32'h595900);
    press(0);
    ticks(990);
    check("pre_wrap", 32'(cur_time), 32'h595999);
    ticks(10);
    check("wrap_zero", 32'(cur_time), 32'h000000);
    check("wrap_running", 32'(running), 32'h1);
    press(2);

    // Down mode expiry
    mode_down = 1'b1;
    do_load(8'h00, 8'h01);
    check("dn_load", 32'(cur_time), 32'h000100);
    press(0);
    check("dn_running", 32'(running), 32'h1);
    ticks(990);
    check("dn_pre", 32'(cur_time), 32'h000001);
    ticks(10);
    check("dn_cur0", 32'(cur_time), 32'h0);
    check("dn_expired", 32'(expired), 32'h1);
    check("dn_not_run", 32'(running), 32'h0);
    press(0);
    press(1);
    check("exp_start_cur", 32'(cur_time), 32'h0);
    check("exp_start_exp", 32'(expired), 32'h1);
    check("exp_start_run", 32'(running), 32'h0);
    check("exp_lap_cnt", 32'(bus.lap_count), 32'h0);
    press(2);
    check("dn_clr_exp", 32'(expired), 32'h0);
    check("dn_clr_preset", 32'(cur_time), 32'h000100);

    // Zero preset rejects start in down mode
    do_load(8'h00, 8'h00);
    press(0);
    check("dn_zero_nostart", 32'(running), 32'h0);
    mode_down = 1'b0;

    // Laps: IDLE lap ignored, then five laps into four entries
    press(1);
    check("idle_lap", 32'(bus.lap_count), 32'h0);
    press(0);
    for (int i = 0; i < 5; i++) begin
      ticks(100);
      press(1);
    end
    check("lap_count", 32'(bus.lap_count), 32'h4);
    check("lap_full", 32'(bus.lap_full), 32'h1);
    for (int i = 0; i < 4; i++) begin
      bus.lap_sel = 2'(i);
      #1;
      check($sformatf("lap_%0d", i), 32'(bus.lap_time), 32'h10 * (i + 1));
    end
    check("lap_cur", 32'(cur_time), 32'h000050);
    press(2);
    bus.lap_sel = 2'd0;
    #1;
    check("lap_empty_read", 32'(bus.lap_time), 32'h0);

    // Pause/resume keeps divider phase
    press(0);
    ticks(505);
    check("pause_pre", 32'(cur_time), 32'h000050);
    press(0);
    check("pause_run", 32'(running), 32'h0);
    ticks(2000);
    check("pause_hold", 32'(cur_time), 32'h000050);
    press(0);
    check("resume_run", 32'(running), 32'h1);
    ticks(4);
    check("resume_4", 32'(cur_time), 32'h000050);
    ticks(1);
    check("resume_51", 32'(cur_time), 32'h000051);
    press(2);

    // clr together with lap and cs_en
    press(0);
    ticks(19);
    check("sim_pre", 32'(cur_time), 32'h000001);
    @(negedge clk);
    ref_tick = 1'b1;
    btn_lap_n = 1'b0;
    btn_clr_n = 1'b0;
    repeat (4) @(negedge clk);
    ref_tick = 1'b0;
    repeat (4) @(negedge clk);
    btn_lap_n = 1'b1;
    btn_clr_n = 1'b1;
    repeat (6) @(negedge clk);
    check("sim_run", 32'(running), 32'h0);
    check("sim_lapcnt", 32'(bus.lap_count), 32'h0);
    check("sim_cur", 32'(cur_time), 32'h0);

    // rst mid-run
    press(0);
    ticks(50);
    press(1);
    check("mid_cur", 32'(cur_time), 32'h000005);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst_cur", 32'(cur_time), 32'h0);
    check("mrst_run", 32'(running), 32'h0);
    check("mrst_exp", 32'(expired), 32'h0);
    check("mrst_lapcnt", 32'(bus.lap_count), 32'h0);
    check("mrst_full", 32'(bus.lap_full), 32'h0);
    check("mrst_laptime", 32'(bus.lap_time), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
- Parametrised successor to the current chronometer: a BCD stopwatch/timer with MM:SS.CC output.
- Adds count-down mode with preset load, expiry detection, and a lap-capture buffer that can be read back by index.
- Sits between the board button/synchroniser logic and the 7-segment display mux.
- Runs in the 50 MHz clk domain; the slow reference tick arrives asynchronously.

Parameters:
TICK_DIV, 10, rising ref_tick edges per centisecond (10 for a 1 kHz ref_tick)
LAP_DEPTH, 4, lap capture entries (2..16)
LAP_IW, 2, lap index width, equal to clog2(LAP_DEPTH)
MIN_MAX, 59, upper minute value in BCD-decimal (59 or 99)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
ref_tick  in  1  asynchronous slow reference clock, 1 kHz nominal
btn_start_n  in  1  start/stop, active low, asynchronous
btn_lap_n  in  1  lap capture, active low, asynchronous
btn_clr_n  in  1  clear counters and laps, active low, asynchronous
mode_down  in  1  0 = count up, 1 = count down; sampled only in IDLE
load  in  1  1-cycle pulse; loads preset, accepted in IDLE only
load_min  in  8  preset minutes, BCD {tens, ones}
load_sec  in  8  preset seconds, BCD {tens, ones}
lap_sel  in  LAP_IW  lap entry read index
cur_time  out  24  live time, BCD {min_t, min_o, sec_t, sec_o, cs_t, cs_o}
lap_time  out  24  lap entry at lap_sel; 0 if lap_sel >= lap_count
lap_count  out  LAP_IW+1  number of stored laps
running  out  1  high in RUN
expired  out  1  high in EXPIRED
lap_full  out  1  high when lap_count == LAP_DEPTH

Behaviour:
- Reset (rst, synchronous): all outputs 0; state IDLE; synchronisers held at their idle levels (buttons 1, ref_tick 0); divider 0; lap buffer empty.
- Input conditioning:
  - ref_tick and each button pass through a 2-FF synchroniser.
  - A tick is a synchronised rising edge of ref_tick.
  - A button event is a synchronised 1->0 edge; exactly one event per press. No debounce here.
- Divider: counts ticks 0..TICK_DIV-1 and emits cs_en on the tick where the count == TICK_DIV-1.
  - The divider runs only in RUN. It holds its value in PAUSE and clears in IDLE.
- State machine (IDLE, RUN, PAUSE, EXPIRED):
  - IDLE --start--> RUN.
    - In down mode, start is ignored if the preset is 00:00.
    - mode_down is latched on this transition.
  - RUN --start--> PAUSE; PAUSE --start--> RUN.
  - RUN --down count reaches 00:00.00--> EXPIRED.
  - Any state --clr--> IDLE.
  - EXPIRED ignores start and lap events.
- Clear: time goes to 0 in up mode, or to the last loaded preset in down mode; lap buffer is emptied; divider goes to 0.
- Load (IDLE only): cur_time = {load_min, load_sec, 00}.
  - Out-of-range digits (ones > 9, sec tens > 5, minutes > MIN_MAX) saturate to the maximum legal value.
  - Load is ignored in every other state.
- Up count on cs_en:
  - Centiseconds 99 -> 00 carries into seconds; seconds 59 -> 00 carries into minutes.
  - Minutes MIN_MAX -> 00 wraps the whole count to 00:00.00 and keeps running.
- Down count on cs_en: mirrored borrow chain.
  - On the cs_en that produces 00:00.00: cur_time = 0, expired = 1, running = 0, all in the same cycle.
- Lap:
  - In RUN or PAUSE, a lap event writes cur_time into entry lap_count and increments lap_count.
  - If lap_count == LAP_DEPTH, the event is dropped and lap_full stays 1.
  - Lap events in IDLE are ignored.
- Simultaneous events, same cycle:
  - clr beats every other event.
  - lap together with cs_en captures the pre-increment value.
  - start together with lap: both are applied, and the lap captures the current value.
  - load together with start in IDLE: the load applies first; start is then evaluated against the loaded value.
- Latency:
  - Button pin to state change: 3 clk.
  - cs_en to cur_time update: 1 clk.
  - lap_time is combinational from lap_sel and the buffer.

Test Plan:
- Up count, TICK_DIV=10, 1 kHz ref_tick, run 1.23 s -> cur_time = 00:01.23 (0x000123); running = 1.
- Preset 59:59.99 via force/load in up mode with MIN_MAX=59, then 1 cs -> wraps to 0x000000 and still running.
- Down mode: load 00:01, start, 100 cs -> expired = 1, cur_time = 0, running = 0; a further start press causes no change.
- Five lap presses at 0.10 s spacing, LAP_DEPTH=4 -> lap_count = 4, lap_full = 1, entries 0x000010/20/30/40; lap_sel=3 returns 0x000040.
- Pause at 00:00.50, hold for 2000 ref_ticks, resume -> cur_time continues from 0x000050 with no skipped centisecond.
- clr asserted during RUN on the same cycle as lap and cs_en -> IDLE, lap_count = 0, cur_time = 0; a subsequent rst mid-run gives all outputs 0.
